// File: rtl/arc4_pkg.sv
// Types shared by the ARC4 decrypt stages (init, ksa, prga).
// Byte type plus the PRGA controller state encoding.
package arc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_LEN,
        ST_WAIT_SI,
        ST_GET_SI,
        ST_WAIT_SJ,
        ST_SWAP_I,
        ST_SWAP_J,
        ST_PAD_ADDR,
        ST_WAIT_PAD,
        ST_WRITE_PT
    } prga_state_e;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: steps the keystream through S memory
// and writes the length-prefixed plaintext CT[k] ^ pad into PT memory.
module prga
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic [7:0]  ct_addr,
    input  logic [7:0]  ct_rddata,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  pt_wrdata,
    output logic        pt_wren
);

    prga_state_e state_q, state_d;
    byte_t       i_q, i_d, j_q, j_d;
    byte_t       si_q, si_d, sj_q, sj_d;
    byte_t       length, length_d;
    byte_t       k, k_d;

    // key and pt_rddata exist only so all ARC4 stages share one port list.
    logic unused_inputs;
    assign unused_inputs = ^{key, pt_rddata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            length  <= '0;
            k       <= '0;
        end else begin
            // NOTE: state is updated with <= so every flop samples the pre-edge values.
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            length  <= length_d;
            k       <= k_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default here, so no latches.
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        length_d  = length;
        k_d       = k;
        rdy       = 1'b0;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = '0;
        pt_addr   = '0;
        pt_wrdata = '0;
        pt_wren   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    length_d = ct_rddata;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = 8'd1;
                    state_d  = ST_WR_LEN;
                end
            end
            ST_WR_LEN: begin
                pt_wrdata = length;
                pt_wren   = 1'b1;
                if (length == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    i_d     = i_q + 8'd1;
                    s_addr  = i_q + 8'd1;
                    state_d = ST_WAIT_SI;
                end
            end
            ST_WAIT_SI: begin
                s_addr  = i_q;
                state_d = ST_GET_SI;
            end
            ST_GET_SI: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                s_addr  = j_q + s_rddata;
                ct_addr = k;
                state_d = ST_WAIT_SJ;
            end
            ST_WAIT_SJ: begin
                s_addr  = j_q;
                ct_addr = k;
                state_d = ST_SWAP_I;
            end
            ST_SWAP_I: begin
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                ct_addr  = k;
                state_d  = ST_SWAP_J;
            end
            ST_SWAP_J: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                ct_addr  = k;
                state_d  = ST_PAD_ADDR;
            end
            ST_PAD_ADDR: begin
                s_addr  = si_q + sj_q;
                ct_addr = k;
                state_d = ST_WAIT_PAD;
            end
            ST_WAIT_PAD: begin
                s_addr  = si_q + sj_q;
                ct_addr = k;
                state_d = ST_WRITE_PT;
            end
            ST_WRITE_PT: begin
                // The PT write overlaps the i increment and S[i] read of the next byte.
                ct_addr   = k;
                pt_addr   = k;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                if (k == length) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = k + 8'd1;
                    i_d     = i_q + 8'd1;
                    s_addr  = i_q + 8'd1;
                    state_d = ST_WAIT_SI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_prga.sv
// Directed bench for prga with behavioural S/CT/PT memories (1-cycle reads)
// and a software ARC4 reference for the long random-permutation run.
module tb_prga;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        rdy;
    logic [23:0] key = 24'h5a5a5a;
    logic [7:0]  s_addr, s_rddata, s_wrdata;
    logic        s_wren;
    logic [7:0]  ct_addr, ct_rddata;
    logic [7:0]  pt_addr, pt_rddata, pt_wrdata;
    logic        pt_wren;

    logic [7:0]  s_mem  [256];
    logic [7:0]  ct_mem [256];
    logic [7:0]  pt_mem [256];
    logic [7:0]  s_ref  [256];
    logic [7:0]  pt_ref [256];
    logic        ct_const = 1'b1;
    int          s_wr_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prga dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    initial begin
        s_rddata  = 8'h00;
        ct_rddata = 8'h00;
        pt_rddata = 8'h00;
    end

    // Synchronous-read memories: read data reflects the address of the previous edge.
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_const ? 8'h19 : ct_mem[ct_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (s_wren) begin
            s_mem[s_addr] = s_wrdata;
            s_wr_cnt++;
        end
        if (pt_wren) pt_mem[pt_addr] = pt_wrdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) begin
            s_mem[x]  = 8'(x);
            ct_mem[x] = 8'h00;
            pt_mem[x] = 8'hAA;
        end
    endtask

    task automatic start_run();
        @(negedge clk) en = 1'b1;
        @(negedge clk) en = 1'b0;
    endtask

    // Called right after start_run; cycles = edges from the en edge to idle.
    task automatic wait_idle(input string tag, input int limit, output int cycles);
        cycles = 1;
        while (rdy !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        if (rdy !== 1'b1) check({tag, "_timeout"}, 32'(rdy), 32'd1);
    endtask

    task automatic ref_arc4(input int len);
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) s_ref[x] = s_mem[x];
        i = 8'h00;
        j = 8'h00;
        pt_ref[0] = ct_mem[0];
        for (int n = 1; n <= len; n++) begin
            i = i + 8'd1;
            j = j + s_ref[i];
            t = s_ref[i];
            s_ref[i] = s_ref[j];
            s_ref[j] = t;
            t = s_ref[i] + s_ref[j];
            pt_ref[n] = s_ref[t] ^ ct_mem[n];
        end
    endtask

    initial begin
        int cycles;
        int cnt0;
        int bad;
        int r;
        logic [7:0] t;

        load_identity();

        // Length latch straight out of power-up with a constant CT read bus.
        repeat (2) @(negedge clk);
        start_run();
        check("len_latch", 32'(dut.length), 32'h19);
        check("busy_after_en", 32'(rdy), 32'd0);
        wait_idle("const_run", 250, cycles);
        check("const_k_final", 32'(dut.k), 32'h19);
        check("const_rdy", 32'(rdy), 32'd1);

        // Proper reset, then check the reset state of the outputs.
        ct_const = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("rst_rdy", 32'(rdy), 32'd1);
        check("rst_outs", {8'h00, s_addr, ct_addr, pt_addr}, 32'h0);
        check("rst_wdata", {16'h0, s_wrdata, pt_wrdata}, 32'h0);
        check("rst_wren", {30'h0, s_wren, pt_wren}, 32'h0);
        check("rst_k_len", {16'h0, dut.k, dut.length}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // One byte, identity S: i=j=1, pad=S[2]=2.
        load_identity();
        ct_mem[0] = 8'd1;
        start_run();
        wait_idle("l1", 40, cycles);
        check("l1_pt0", 32'(pt_mem[0]), 32'd1);
        check("l1_pt1", 32'(pt_mem[1]), 32'h02);
        check("l1_s1", 32'(s_mem[1]), 32'd1);
        check("l1_k", 32'(dut.k), 32'd1);

        // Two bytes: second byte swaps S[2]/S[3], pad=S[5]=5, 5^FF=FA.
        load_identity();
        ct_mem[0] = 8'd2;
        ct_mem[2] = 8'hFF;
        start_run();
        wait_idle("l2", 40, cycles);
        check("l2_pt0", 32'(pt_mem[0]), 32'd2);
        check("l2_pt1", 32'(pt_mem[1]), 32'h02);
        check("l2_pt2", 32'(pt_mem[2]), 32'hFA);
        check("l2_s2", 32'(s_mem[2]), 32'd3);
        check("l2_s3", 32'(s_mem[3]), 32'd2);
        check("l2_cycles_le_22", 32'(cycles <= 22), 32'd1);

        // Empty message: only PT[0] written, no S traffic.
        load_identity();
        ct_mem[0] = 8'd0;
        cnt0 = s_wr_cnt;
        start_run();
        wait_idle("l0", 4, cycles);
        check("l0_pt0", 32'(pt_mem[0]), 32'd0);
        check("l0_pt1_untouched", 32'(pt_mem[1]), 32'hAA);
        check("l0_no_s_wr", 32'(s_wr_cnt - cnt0), 32'd0);
        check("l0_k", 32'(dut.k), 32'd1);

        // Asynchronous reset in the middle of an S write.
        load_identity();
        ct_mem[0] = 8'd255;
        start_run();
        cycles = 0;
        while (s_wren !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check("mid_swren_seen", 32'(s_wren), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(rdy), 32'd1);
        check("mid_rst_wren", {30'h0, s_wren, pt_wren}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        load_identity();
        ct_mem[0] = 8'd2;
        ct_mem[2] = 8'hFF;
        start_run();
        wait_idle("post_rst", 40, cycles);
        check("post_rst_pt1", 32'(pt_mem[1]), 32'h02);
        check("post_rst_pt2", 32'(pt_mem[2]), 32'hFA);

        // Random permutation, L=255, en pulsed while busy.
        for (int x = 0; x < 256; x++) begin
            s_mem[x]  = 8'(x);
            ct_mem[x] = 8'($urandom_range(255, 0));
            pt_mem[x] = 8'hAA;
        end
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = s_mem[x];
            s_mem[x] = s_mem[r];
            s_mem[r] = t;
        end
        ct_mem[0] = 8'd255;
        ref_arc4(255);
        start_run();
        for (int n = 0; n < 5; n++) begin
            repeat (7) @(negedge clk);
            en = 1'b1;
            @(negedge clk) en = 1'b0;
        end
        check("busy_len_kept", 32'(dut.length), 32'd255);
        check("busy_no_restart", 32'(rdy), 32'd0);
        wait_idle("l255", 2400, cycles);
        check("l255_k", 32'(dut.k), 32'd255);
        check("l255_cycles_le_2299", 32'(cycles <= 2299), 32'd1);
        for (int x = 0; x < 256; x++) check($sformatf("l255_pt%0d", x), 32'(pt_mem[x]), 32'(pt_ref[x]));
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== s_ref[x]) bad++;
        check("l255_s_state_mismatches", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
